// File: rtl/run_len_pkg.sv
// Shared types and default sizes for the run-length counter that follows mealy_fsm.
package run_len_pkg;

    localparam int CNT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] len;
    } run_entry_t;

endpackage

// File: rtl/run_len_fifo.sv
// First-word-fall-through FIFO with count-based full/empty; head reads as zero when empty.
module run_len_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    // A pop frees the slot in the same edge, so a push into a full FIFO is accepted then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/run_length_counter.sv
// Measures each maximal run of 1s on a serial stream and queues the lengths
// (with a saturation flag) for a valid/ready consumer.
import run_len_pkg::*;

module run_length_counter #(
    parameter  int CNT_W      = CNT_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [CNT_W-1:0] len_out,
    output logic             len_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] len;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, full, empty;
    entry_t           wr_entry, head;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        push    = 1'b0;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (bit_in) begin
                        state_d = RUN;
                        cnt_d   = CNT_ONE;
                        sat_d   = (CNT_ONE == CNT_MAX);
                    end
                end
                RUN: begin
                    if (bit_in) begin
                        // Count pins at CNT_MAX; the flag marks that the true length may be larger.
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q >= CNT_MAX - CNT_ONE) sat_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop   = ~empty & out_ready;
    assign ovf_d = ovf_q | (push & full & ~pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_entry.sat = sat_q;
    assign wr_entry.len = cnt_q;

    run_len_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (wr_entry),
        .pop_i     (pop),
        .rd_data_o (head),
        .count_o   (fifo_count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign out_valid = ~empty;
    assign len_out   = head.len;
    assign len_sat   = head.sat;
    assign overflow  = ovf_q;

endmodule
